// File: rtl/fp_defs.sv
// Shared definitions for the 24-bit float format: {sign, exp[6:0] bias 63, frac[15:0]}.
// Also holds the divider state encoding and the normalise result bundle.
package fp_defs;

  localparam int FRAC_W   = 16;
  localparam int EXP_W    = 7;
  localparam int BIAS     = 63;
  localparam int WORD_W   = 1 + EXP_W + FRAC_W;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int Q_W      = FRAC_W + 2;

  localparam int SIGN_BIT = 23;
  localparam int EXP_HI   = 22;
  localparam int EXP_LO   = 16;
  localparam int FRAC_HI  = 15;
  localparam int FRAC_LO  = 0;

  localparam logic [WORD_W-2:0] ZERO    = 23'h000000;
  localparam logic [WORD_W-2:0] MAX_MAG = 23'h7FFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic              underflow;
    logic              overflow;
  } norm_t;

endpackage

// File: rtl/mantissa_divider.sv
// Restoring mantissa divider: q = floor(ma * 2^17 / mb), one quotient bit per cycle, MSB first.
// start loads the operands; done pulses for one cycle once all 18 bits are in q.
module mantissa_divider
  import fp_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    q
);

  logic [4:0]        cnt;
  logic [Q_W-1:0]    rem;
  logic [MANT_W-1:0] mb_r;
  logic              ge;
  logic [Q_W-1:0]    sub;
  logic [Q_W-1:0]    r_sel;

  // rem stays below 2*mb, so after a successful subtract it fits back in 17 bits
  assign ge    = (rem >= {1'b0, mb_r});
  assign sub   = rem - {1'b0, mb_r};
  assign r_sel = ge ? sub : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'(Q_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem  <= {1'b0, ma};
      mb_r <= mb;
      q    <= '0;
    end else if (busy) begin
      rem <= r_sel << 1;
      q   <= {q[Q_W-2:0], ge};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Iterative 24-bit float divider a / b behind valid/ready handshakes.
// Handles zero operands up front; normal operands go through the mantissa core then normalise.
module fp_divider
  import fp_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_underflow,
  output logic              out_overflow,
  output logic              out_div_by_zero
);

  state_t             state, state_nxt;
  logic               sign_r;
  logic signed [8:0]  e_r;
  logic signed [8:0]  e_in;
  logic               accept, a_zero, b_zero, special, sign_in;
  logic               div_start, div_busy, div_done;
  logic [Q_W-1:0]     div_q;
  norm_t              norm_res;

  function automatic norm_t normalize(input logic sign, input logic [Q_W-1:0] q,
                                      input logic signed [8:0] e);
    logic signed [8:0] exp_f;
    logic [FRAC_W-1:0] frac_f;
    norm_t             r;
    if (q[Q_W-1]) begin
      frac_f = q[FRAC_W:1];
      exp_f  = e;
    end else begin
      frac_f = q[FRAC_W-1:0];
      exp_f  = e - 9'sd1;
    end
    r.underflow = 1'b0;
    r.overflow  = 1'b0;
    if (exp_f < 9'sd0) begin
      r.underflow = 1'b1;
      r.result    = {sign, ZERO};
    end else if (exp_f > 9'sd127) begin
      r.overflow = 1'b1;
      r.result   = {sign, MAX_MAG};
    end else begin
      r.result = {sign, exp_f[EXP_W-1:0], frac_f};
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign a_zero    = (in_a[SIGN_BIT-1:0] == ZERO);
  assign b_zero    = (in_b[SIGN_BIT-1:0] == ZERO);
  assign special   = a_zero || b_zero;
  assign sign_in   = in_a[SIGN_BIT] ^ in_b[SIGN_BIT];
  assign div_start = accept && !special;
  assign e_in      = $signed({2'b00, in_a[EXP_HI:EXP_LO]}) - $signed({2'b00, in_b[EXP_HI:EXP_LO]})
                     + $signed(9'(BIAS));
  assign norm_res  = normalize(sign_r, div_q, e_r);

  mantissa_divider u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .ma    ({1'b1, in_a[FRAC_HI:FRAC_LO]}),
    .mb    ({1'b1, in_b[FRAC_HI:FRAC_LO]}),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : DIVIDE;
      DIVIDE:  if (div_done && !div_busy) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers only change on a special-case accept or in NORM, so DONE holds them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      out_result      <= '0;
      out_underflow   <= 1'b0;
      out_overflow    <= 1'b0;
      out_div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && b_zero) begin
        out_result      <= {sign_in, MAX_MAG};
        out_underflow   <= 1'b0;
        out_overflow    <= 1'b0;
        out_div_by_zero <= 1'b1;
      end else if (accept && a_zero) begin
        out_result      <= {sign_in, ZERO};
        out_underflow   <= 1'b0;
        out_overflow    <= 1'b0;
        out_div_by_zero <= 1'b0;
      end else if (state == NORM) begin
        out_result      <= norm_res.result;
        out_underflow   <= norm_res.underflow;
        out_overflow    <= norm_res.overflow;
        out_div_by_zero <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r <= sign_in;
      e_r    <= e_in;
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: hand-computed quotients, flags, latency, backpressure and reset.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic        out_underflow;
  logic        out_overflow;
  logic        out_div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_underflow   (out_underflow),
    .out_overflow    (out_overflow),
    .out_div_by_zero (out_div_by_zero)
  );

  // Presents one operand pair and returns #1 after the accept edge.
  task automatic start_op(input logic [23:0] a, input logic [23:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 24'h5A5A5A;
    in_b     = 24'h3C3C3C;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_wait: out_valid=%b required 1 after %0d edges", out_valid, lat);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, out_valid, out_result, out_underflow, out_overflow, out_div_by_zero}
        !== {1'b1, 1'b0, 24'h000000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h flags=%b%b%b required 1 0 000000 000",
               in_ready, out_valid, out_result, out_underflow, out_overflow, out_div_by_zero);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op(24'h418000, 24'h400000);
    wait_result(lat);
    n_cmp++;
    if (lat !== 20) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d edges required 20", lat);
    end
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h408000, 3'b000}) begin
      n_bad++;
      $display("FAIL basic_6_div_2: got %h flags %b%b%b required 408000 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_handshake: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_truncate();
    int lat;
    start_op(24'h3F0000, 24'h408000);
    wait_result(lat);
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h3D5555, 3'b000}) begin
      n_bad++;
      $display("FAIL trunc_1_div_3: got %h flags %b%b%b required 3D5555 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
    start_op(24'hBF0000, 24'h400000);
    wait_result(lat);
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'hBE0000, 3'b000}) begin
      n_bad++;
      $display("FAIL neg_1_div_2: got %h flags %b%b%b required BE0000 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
  endtask

  task automatic test_range();
    int lat;
    start_op(24'h7F0000, 24'h010000);
    wait_result(lat);
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h7FFFFF, 3'b010}) begin
      n_bad++;
      $display("FAIL overflow: got %h flags %b%b%b required 7FFFFF 010",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
    start_op(24'h010000, 24'h7F0000);
    wait_result(lat);
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h000000, 3'b100}) begin
      n_bad++;
      $display("FAIL underflow: got %h flags %b%b%b required 000000 100",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
  endtask

  task automatic test_special();
    int lat;
    start_op(24'h3F0000, 24'h000000);
    wait_result(lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL div0_latency: got %0d edges required 1", lat);
    end
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h7FFFFF, 3'b001}) begin
      n_bad++;
      $display("FAIL div_by_zero: got %h flags %b%b%b required 7FFFFF 001",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
    start_op(24'h000000, 24'hBF0000);
    wait_result(lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL zero_a_latency: got %0d edges required 1", lat);
    end
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h800000, 3'b000}) begin
      n_bad++;
      $display("FAIL zero_dividend: got %h flags %b%b%b required 800000 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(24'h418000, 24'h400000);
    wait_result(lat);
    @(negedge clk);
    in_a     = 24'h3F0000;
    in_b     = 24'h408000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_result, out_underflow, out_overflow, out_div_by_zero}
          !== {1'b1, 1'b0, 24'h408000, 3'b000}) begin
        n_bad++;
        $display("FAIL hold_cycle_%0d: vld=%b rdy=%b res=%h flags=%b%b%b required 1 0 408000 000",
                 i, out_valid, in_ready, out_result, out_underflow, out_overflow, out_div_by_zero);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL hold_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL next_accept: rdy=%b required 0", in_ready);
    end
    wait_result(lat);
    n_cmp++;
    if (lat !== 20) begin
      n_bad++;
      $display("FAIL next_latency: got %0d edges required 20", lat);
    end
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h3D5555, 3'b000}) begin
      n_bad++;
      $display("FAIL next_result: got %h flags %b%b%b required 3D5555 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(24'h418000, 24'h400000);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_result, out_underflow, out_overflow, out_div_by_zero}
        !== {1'b1, 1'b0, 24'h000000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h flags=%b%b%b required 1 0 000000 000",
               in_ready, out_valid, out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_op(24'h418000, 24'h400000);
    wait_result(lat);
    n_cmp++;
    if (lat !== 20) begin
      n_bad++;
      $display("FAIL after_reset_latency: got %0d edges required 20", lat);
    end
    n_cmp++;
    if ({out_result, out_underflow, out_overflow, out_div_by_zero} !== {24'h408000, 3'b000}) begin
      n_bad++;
      $display("FAIL after_reset_result: got %h flags %b%b%b required 408000 000",
               out_result, out_underflow, out_overflow, out_div_by_zero);
    end
    release_result();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 24'h0;
    in_b      = 24'h0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_basic();
    test_truncate();
    test_range();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
